rom_loader: RTL and testbench
=============================

# rom_loader

Sits between the `data_io` download stream and the `sdram` ROM controller on the 48 MHz system clock. It packs `ioctl` bytes into byte-lane SDRAM writes through a small FIFO, and tracks download completion to drive the core reset. After loading, it serves the game core's ROM byte reads through a request/acknowledge handshake to `sdram`, using a one-word tag cache.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: number of write FIFO entries; power of two, minimum 2.
- `ROM_INDEX`, 8'd0: the `ioctl_index` value whose bytes are written; other indices are ignored.

Ports:
- `clk_sys` in 1: system clock, 48 MHz.
- `reset` in 1: synchronous, active-high; one clock domain only.
- `ioctl_download` in 1: download in progress.
- `ioctl_index` in 8: download index.
- `ioctl_wr` in 1: one-cycle byte strobe.
- `ioctl_addr` in 25: byte address.
- `ioctl_dout` in 8: byte data.
- `core_addr` in 15: core ROM byte address.
- `core_dout` out 8: byte at `core_addr`.
- `core_valid` out 1: `core_dout` corresponds to the current `core_addr`.
- `sd_addr` out 25: SDRAM byte address; bit 0 is ignored on reads.
- `sd_din` out 16: write data, `{byte,byte}`.
- `sd_wtbt` out 2: byte-lane enables.
- `sd_we` out 1: write request, held until ack.
- `sd_rd` out 1: read request, held until ack.
- `sd_ack` in 1: one-cycle completion; `sd_dout` is valid in that cycle.
- `sd_dout` in 16: read word.
- `rom_loaded` out 1: sticky; download completed and drained.
- `core_reset` out 1: `reset | ~rom_loaded`, registered.
- `overflow` out 1: sticky; a byte was dropped because the FIFO was full.

## Operation
- **FIFO push:** occurs when `ioctl_wr & ioctl_download & ioctl_index==ROM_INDEX`. Each entry is `{addr[24:0], byte}`.
- **States:** IDLE, WRITE, READ, DRAIN.
- **IDLE:**
  - FIFO non-empty → WRITE. Writes have priority over reads.
  - Otherwise, if `rom_loaded & ~ioctl_download` and a read is needed → READ.
  - Falling edge of `ioctl_download` (registered) → DRAIN.
- **WRITE:**
  - Pop the head entry.
  - Drive `sd_addr`=entry addr, `sd_din`={b,b}, `sd_wtbt`= addr[0] ? 2'b10 : 2'b01, `sd_we`=1.
  - On `sd_ack`: deassert `sd_we` and return to IDLE. The entry is popped at ack.
- **DRAIN:** when the FIFO is empty and no write is outstanding, set `rom_loaded`=1 and go to IDLE.
- **READ:**
  - Drive `sd_addr`={10'd0, core_addr[14:1], 1'b0} and `sd_rd`=1.
  - On `sd_ack`: latch `sd_dout` into the word register, set tag=`core_addr[14:1]` and tag_valid=1, then go to IDLE.
- **Read needed:** `~tag_valid | tag != core_addr[14:1]`.
- **Byte select:** `core_dout` = `core_addr[0]` ? word[15:8] : word[7:0]. `core_valid` = `tag_valid & tag==core_addr[14:1] & rom_loaded & ~ioctl_download`.
- **Address change during READ:** the request completes to the old tag. `core_valid` stays low, and IDLE immediately reissues the read for the new address.
- **Rising edge of `ioctl_download`:** clears `rom_loaded` and `tag_valid`. Because `core_reset` is derived from `rom_loaded`, the core is held in reset.
- **FIFO full with a push:** the byte is dropped and `overflow` is set. `overflow` is cleared only by `reset`.
- **Push and pop in the same cycle:** both occur. The count is unchanged, and pointers wrap modulo `FIFO_DEPTH`.
- **Reset mid-operation:** outputs take their reset values on the next edge, and an outstanding `sd_ack` is ignored. The FIFO is emptied, tag_valid is cleared, and the state goes to IDLE.

## Timing
- **Reset values:**
  - `sd_we`, `sd_rd`, `core_valid`, `rom_loaded`, `overflow`: 0.
  - `core_reset`: 1.
  - `sd_addr`, `sd_din`, `sd_wtbt`, `core_dout`: 0.
- **Write path:** `ioctl_wr` at edge N → FIFO entry at N+1 → `sd_we` asserted at N+2 when IDLE.
- **Read path:** a miss detected at edge N → `sd_rd` at N+1 → ack at cycle A → `core_valid` at A+1.
- **Hit:** `core_valid` is asserted combinationally from registered tag state, with zero added latency.
- **Completion:** `rom_loaded` rises at most 1 cycle after the last write ack following the download fall. `core_reset` falls 1 cycle after `rom_loaded` rises.
- **Handshake:** `sd_we` and `sd_rd` are never asserted together. Address and data are stable while a request is held.

## Configuration
- `ROM_LOADER_CACHE_EN` defined: the one-word tag cache operates as described above.
- `ROM_LOADER_CACHE_EN` undefined:
  - tag_valid is cleared every time `core_addr` changes, so every address change issues a read, including changes that stay within the same word.
  - `core_valid` still requires the tag to match.

## Structure
- Package `rom_loader_pkg`:
  - state enum `rl_state_t` (IDLE, WRITE, READ, DRAIN);
  - struct `rl_fifo_entry_t` {logic [24:0] addr; logic [7:0] data;};
  - localparams `SD_AW`=25 and `CORE_AW`=15.
- Sub-module `rom_wr_fifo`, parameterised by `FIFO_DEPTH`:
  - synchronous reset;
  - push, pop, full, empty, head.

## Test plan
- **Single write:** a download of 2 bytes at addr 0 (0xAA) and 1 (0x55) → `sd_we` twice. First transaction: `sd_wtbt`=01, `sd_din`=AAAA. Second: `sd_wtbt`=10, `sd_din`=5555. `rom_loaded`=1 after the second ack.
- **Overflow:** 6 back-to-back `ioctl_wr` with `sd_ack` withheld and `FIFO_DEPTH`=4 → exactly 4 writes are issued and `overflow`=1.
- **Read hit and miss:**
  - `core_addr`=0x0100 with `sd_dout`=0x1234 → `core_dout`=0x34 and `core_valid` at ack+1.
  - `core_addr`=0x0101 → 0x12 with no `sd_rd`.
  - With the macro undefined, the second access issues `sd_rd`.
- **Address change during READ:** `core_addr` changes from 0x0200 to 0x0300 before ack → a second `sd_rd` with `sd_addr`=0x300, and `core_valid` is low until its ack.
- **Index filter and redownload:** `ioctl_index`=1 bytes → no `sd_we`. Raising `ioctl_download` after load → `rom_loaded`=0, `core_reset`=1, `core_valid`=0.
- **Mid-operation reset:** `reset` asserted while `sd_we` is held → `sd_we`=0 and `core_reset`=1 next cycle, and the FIFO is empty.

Source files
------------

// File: rtl/rom_loader_pkg.sv
// rtl/rom_loader_pkg.sv - shared types and widths for the ROM download/read bridge
// Contents:
//   rl_state_t      : controller state (IDLE, WRITE, READ, DRAIN)
//   rl_fifo_entry_t : one buffered download byte with its SDRAM byte address
//   SD_AW, CORE_AW  : SDRAM and core ROM byte-address widths
package rom_loader_pkg;

  localparam int SD_AW   = 25;
  localparam int CORE_AW = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } rl_state_t;

  typedef struct packed {
    logic [SD_AW-1:0] addr;
    logic [7:0]       data;
  } rl_fifo_entry_t;

endpackage

// File: rtl/rom_wr_fifo.sv
// rtl/rom_wr_fifo.sv - small write FIFO buffering download bytes ahead of SDRAM
// Ports:
//   clk_sys, reset     : system clock, synchronous active-high reset (empties FIFO)
//   push, push_entry   : write request and entry; ignored while full
//   pop                : drop the head entry; ignored while empty
//   full, empty        : occupancy flags
//   head               : oldest entry, valid while not empty
module rom_wr_fifo
  import rom_loader_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk_sys,
  input  logic           reset,
  input  logic           push,
  input  rl_fifo_entry_t push_entry,
  input  logic           pop,
  output logic           full,
  output logic           empty,
  output rl_fifo_entry_t head
);

  localparam int PW = $clog2(FIFO_DEPTH);

  rl_fifo_entry_t mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (PW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_sys) begin
    if (do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - packs ioctl download bytes into SDRAM writes and serves core ROM reads
// Build option: ROM_LOADER_CACHE_EN keeps the one-word tag cache across core_addr changes;
//   when undefined, every core_addr change invalidates the cached word.
// Ports:
//   clk_sys, reset                 : 48 MHz system clock, synchronous active-high reset
//   ioctl_download/index/wr/addr/dout : data_io download byte stream
//   core_addr, core_dout, core_valid  : game core ROM byte read port
//   sd_addr/din/wtbt/we/rd, sd_ack, sd_dout : request/ack port to the sdram controller
//   rom_loaded, core_reset, overflow  : load status, core reset, sticky FIFO drop flag
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] ROM_INDEX  = 8'd0
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               ioctl_download,
  input  logic [7:0]         ioctl_index,
  input  logic               ioctl_wr,
  input  logic [SD_AW-1:0]   ioctl_addr,
  input  logic [7:0]         ioctl_dout,
  input  logic [CORE_AW-1:0] core_addr,
  output logic [7:0]         core_dout,
  output logic               core_valid,
  output logic [SD_AW-1:0]   sd_addr,
  output logic [15:0]        sd_din,
  output logic [1:0]         sd_wtbt,
  output logic               sd_we,
  output logic               sd_rd,
  input  logic               sd_ack,
  input  logic [15:0]        sd_dout,
  output logic               rom_loaded,
  output logic               core_reset,
  output logic               overflow
);

  rl_state_t      state;
  rl_state_t      state_next;
  rl_fifo_entry_t push_entry;
  rl_fifo_entry_t head;
  logic           push_req;
  logic           fifo_pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic           download_q;
  logic           dl_rise;
  logic           dl_fall;
  logic           drain_pend;
  logic           start_write;
  logic           start_read;
  logic           set_loaded;
  logic           read_needed;
  logic           addr_moved;
  logic           tag_valid;
  logic [13:0]    tag;
  logic [13:0]    rd_tag;
  logic [15:0]    word;

  assign push_req   = ioctl_wr & ioctl_download & (ioctl_index == ROM_INDEX);
  assign push_entry = '{addr: ioctl_addr, data: ioctl_dout};
  assign fifo_pop   = (state == ST_WRITE) & sd_ack;
  assign dl_rise    = ioctl_download & ~download_q;
  assign dl_fall    = ~ioctl_download & download_q;

  rom_wr_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .push       (push_req),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (head)
  );

`ifdef ROM_LOADER_CACHE_EN
  assign addr_moved = 1'b0;
`else
  logic [CORE_AW-1:0] core_addr_q;

  always_ff @(posedge clk_sys) begin
    if (reset) core_addr_q <= '0;
    else       core_addr_q <= core_addr;
  end

  assign addr_moved = (core_addr != core_addr_q);
`endif

  assign read_needed = ~tag_valid | (tag != core_addr[14:1]);
  assign core_valid  = tag_valid & (tag == core_addr[14:1]) & rom_loaded & ~ioctl_download;
  assign core_dout   = core_addr[0] ? word[15:8] : word[7:0];

  // The download fall is only a one-cycle pulse, so it is remembered in drain_pend
  // until the FIFO has emptied and rom_loaded can be raised.
  always_comb begin
    state_next  = state;
    start_write = 1'b0;
    start_read  = 1'b0;
    set_loaded  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_next  = ST_WRITE;
          start_write = 1'b1;
        end else if (drain_pend) begin
          state_next = ST_DRAIN;
        end else if (rom_loaded && !ioctl_download && read_needed) begin
          state_next = ST_READ;
          start_read = 1'b1;
        end
      end
      ST_WRITE: begin
        // Going straight to DRAIN lets rom_loaded rise one cycle after the last ack.
        if (sd_ack) state_next = drain_pend ? ST_DRAIN : ST_IDLE;
      end
      ST_READ: begin
        if (sd_ack) state_next = ST_IDLE;
      end
      ST_DRAIN: begin
        if (!fifo_empty) begin
          state_next  = ST_WRITE;
          start_write = 1'b1;
        end else begin
          state_next = ST_IDLE;
          set_loaded = drain_pend;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= ST_IDLE;
      download_q <= 1'b0;
      drain_pend <= 1'b0;
      rom_loaded <= 1'b0;
      core_reset <= 1'b1;
      overflow   <= 1'b0;
      tag_valid  <= 1'b0;
      tag        <= '0;
      rd_tag     <= '0;
      word       <= '0;
      sd_addr    <= '0;
      sd_din     <= '0;
      sd_wtbt    <= '0;
      sd_we      <= 1'b0;
      sd_rd      <= 1'b0;
    end else begin
      state      <= state_next;
      download_q <= ioctl_download;
      core_reset <= ~rom_loaded;

      if (push_req && fifo_full) overflow <= 1'b1;

      if (dl_rise) begin
        drain_pend <= 1'b0;
        rom_loaded <= 1'b0;
      end else begin
        if (dl_fall) drain_pend <= 1'b1;
        if (set_loaded) begin
          rom_loaded <= 1'b1;
          drain_pend <= 1'b0;
        end
      end

      if (start_write) begin
        sd_addr <= head.addr;
        sd_din  <= {head.data, head.data};
        sd_wtbt <= head.addr[0] ? 2'b10 : 2'b01;
        sd_we   <= 1'b1;
      end else if (state == ST_WRITE && sd_ack) begin
        sd_we <= 1'b0;
      end

      // rd_tag remembers the word actually requested, so a core_addr change while
      // the read is in flight still completes against the old tag.
      if (start_read) begin
        sd_addr <= {10'd0, core_addr[14:1], 1'b0};
        sd_rd   <= 1'b1;
        rd_tag  <= core_addr[14:1];
      end else if (state == ST_READ && sd_ack) begin
        sd_rd <= 1'b0;
        word  <= sd_dout;
        tag   <= rd_tag;
      end

      if (dl_rise || addr_moved) begin
        tag_valid <= 1'b0;
      end else if (state == ST_READ && sd_ack && !ioctl_download) begin
        tag_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - scoreboard bench for rom_loader
module tb_rom_loader;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [14:0] core_addr;
  logic [7:0]  core_dout;
  logic        core_valid;
  logic [24:0] sd_addr;
  logic [15:0] sd_din;
  logic [1:0]  sd_wtbt;
  logic        sd_we;
  logic        sd_rd;
  logic        sd_ack;
  logic [15:0] sd_dout;
  logic        rom_loaded;
  logic        core_reset;
  logic        overflow;

  int n_vec = 0;
  int n_err = 0;
  int n_wr  = 0;
  int n_rd  = 0;
  int base_wr;
  int base_rd;
  int ack_lat;
  int wait_cnt;
  bit ack_en;
  bit we_prev;
  bit rd_prev;
  logic [42:0] exp_wr [$];
  logic [24:0] exp_rd [$];
  logic [42:0] e_wr;
  logic [24:0] e_rd;

  always #10 clk_sys = ~clk_sys;

  rom_loader #(
    .FIFO_DEPTH (4),
    .ROM_INDEX  (8'd0)
  ) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .core_addr      (core_addr),
    .core_dout      (core_dout),
    .core_valid     (core_valid),
    .sd_addr        (sd_addr),
    .sd_din         (sd_din),
    .sd_wtbt        (sd_wtbt),
    .sd_we          (sd_we),
    .sd_rd          (sd_rd),
    .sd_ack         (sd_ack),
    .sd_dout        (sd_dout),
    .rom_loaded     (rom_loaded),
    .core_reset     (core_reset),
    .overflow       (overflow)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // SDRAM contents as seen by reads
  function automatic logic [15:0] sd_word(input logic [24:0] a);
    case (a)
      25'h100: sd_word = 16'h1234;
      25'h200: sd_word = 16'hABCD;
      25'h300: sd_word = 16'h5678;
      default: sd_word = {a[8:1], a[16:9]};
    endcase
  endfunction

  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  // which: 0 rom_loaded, 1 core_valid, 2 sd_ack, 3 sd_rd, 4 sd_we
  task automatic wait_for(input int which, input int bound, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < bound && !hit; i++) begin
      tick();
      case (which)
        0: hit = rom_loaded;
        1: hit = core_valid;
        2: hit = sd_ack;
        3: hit = sd_rd;
        default: hit = sd_we;
      endcase
    end
    chk(tag, {63'b0, hit}, 64'd1);
  endtask

  task automatic ioctl_byte(input logic [24:0] a, input logic [7:0] d, input bit expect_it);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    if (expect_it) exp_wr.push_back({a, d, d, (a[0] ? 2'b10 : 2'b01)});
  endtask

  // SDRAM responder: acks held requests after ack_lat cycles and scores each transaction.
  initial begin
    sd_ack   = 1'b0;
    sd_dout  = 16'hDEAD;
    wait_cnt = 0;
    we_prev  = 1'b0;
    rd_prev  = 1'b0;
    forever begin
      @(negedge clk_sys);
      sd_ack  = 1'b0;
      sd_dout = 16'hDEAD;
      if (sd_we && !we_prev) n_wr++;
      if (sd_rd && !rd_prev) n_rd++;
      we_prev = sd_we;
      rd_prev = sd_rd;
      if (!reset && ack_en && (sd_we || sd_rd)) begin
        if (wait_cnt < ack_lat) begin
          wait_cnt++;
        end else begin
          wait_cnt = 0;
          chk("we_rd_excl", {63'b0, sd_we & sd_rd}, 64'd0);
          if (sd_we) begin
            if (exp_wr.size() == 0) begin
              chk("wr_extra", {39'b0, sd_addr}, 64'hFFFF_FFFF);
            end else begin
              e_wr = exp_wr.pop_front();
              chk("wr_txn", {21'b0, sd_addr, sd_din, sd_wtbt}, {21'b0, e_wr});
            end
          end else begin
            if (exp_rd.size() == 0) begin
              chk("rd_extra", {39'b0, sd_addr}, 64'hFFFF_FFFF);
            end else begin
              e_rd = exp_rd.pop_front();
              chk("rd_addr", {39'b0, sd_addr}, {39'b0, e_rd});
            end
            sd_dout = sd_word(sd_addr);
          end
          sd_ack = 1'b1;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    core_addr      = 15'h0100;
    ack_en         = 1'b1;
    ack_lat        = 2;

    // reset values
    repeat (3) tick();
    chk("rst_we",    {63'b0, sd_we},      64'd0);
    chk("rst_rd",    {63'b0, sd_rd},      64'd0);
    chk("rst_valid", {63'b0, core_valid}, 64'd0);
    chk("rst_load",  {63'b0, rom_loaded}, 64'd0);
    chk("rst_ovf",   {63'b0, overflow},   64'd0);
    chk("rst_crst",  {63'b0, core_reset}, 64'd1);
    chk("rst_bus",   {21'b0, sd_addr, sd_din, sd_wtbt}, 64'd0);
    chk("rst_dout",  {56'b0, core_dout},  64'd0);
    reset = 1'b0;
    tick();

    // two-byte download, write latency, completion, first read miss
    ioctl_download = 1'b1;
    tick();
    ioctl_byte(25'h0, 8'hAA, 1'b1);
    tick();
    ioctl_wr = 1'b0;
    chk("wr_lat_n1", {63'b0, sd_we}, 64'd0);
    tick();
    chk("wr_lat_n2", {63'b0, sd_we}, 64'd1);
    repeat (6) tick();
    ioctl_byte(25'h1, 8'h55, 1'b1);
    tick();
    ioctl_wr = 1'b0;
    repeat (2) tick();
    exp_rd.push_back(25'h100);
    ioctl_download = 1'b0;
    wait_for(0, 40, "load_tmo");
    chk("load_nwr",   n_wr, 2);
    chk("load_wrq",   exp_wr.size(), 0);
    chk("crst_hold",  {63'b0, core_reset}, 64'd1);
    tick();
    chk("crst_fall",  {63'b0, core_reset}, 64'd0);
    wait_for(2, 20, "rd1_ack_tmo");
    chk("rd1_pre",    {63'b0, core_valid}, 64'd0);
    tick();
    chk("rd1_valid",  {63'b0, core_valid}, 64'd1);
    chk("rd1_dout",   {56'b0, core_dout}, 64'h34);

    // same word, odd byte
    base_rd   = n_rd;
    core_addr = 15'h0101;
`ifdef ROM_LOADER_CACHE_EN
    chk("hit_valid", {63'b0, core_valid}, 64'd1);
    chk("hit_dout",  {56'b0, core_dout}, 64'h12);
    repeat (6) tick();
    chk("hit_nrd",   n_rd - base_rd, 0);
`else
    exp_rd.push_back(25'h100);
    wait_for(1, 30, "nc_valid_tmo");
    chk("nc_dout",   {56'b0, core_dout}, 64'h12);
    chk("nc_nrd",    n_rd - base_rd, 1);
`endif

    // address change while a read is in flight
    ack_lat   = 6;
    base_rd   = n_rd;
    core_addr = 15'h0200;
    exp_rd.push_back(25'h200);
    wait_for(3, 10, "chg_rd_tmo");
    tick();
    core_addr = 15'h0300;
    exp_rd.push_back(25'h300);
    wait_for(2, 20, "chg_ack_tmo");
    tick();
    chk("chg_lo",    {63'b0, core_valid}, 64'd0);
    wait_for(1, 30, "chg_valid_tmo");
    chk("chg_nrd",   n_rd - base_rd, 2);
    chk("chg_dout",  {56'b0, core_dout}, 64'h78);
    ack_lat = 2;

    // foreign index is filtered; redownload drops the load state
    base_wr        = n_wr;
    ioctl_index    = 8'd1;
    ioctl_download = 1'b1;
    repeat (2) tick();
    chk("redl_load",  {63'b0, rom_loaded}, 64'd0);
    chk("redl_crst",  {63'b0, core_reset}, 64'd1);
    chk("redl_valid", {63'b0, core_valid}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      ioctl_byte(25'h40 + 25'(i), 8'h90 + 8'(i), 1'b0);
      tick();
    end
    ioctl_wr = 1'b0;
    repeat (6) tick();
    chk("idx_nwr", n_wr - base_wr, 0);
    ioctl_index = 8'd0;
    exp_rd.push_back(25'h300);
    ioctl_download = 1'b0;
    wait_for(0, 30, "idx_load_tmo");
    wait_for(1, 30, "idx_valid_tmo");
    chk("idx_dout", {56'b0, core_dout}, 64'h78);

    // overflow with ack withheld
    base_wr        = n_wr;
    ack_en         = 1'b0;
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      ioctl_byte(25'h10 + 25'(i), 8'hC0 + 8'(i), i < 4);
      tick();
    end
    ioctl_wr = 1'b0;
    tick();
    chk("ovf_set", {63'b0, overflow}, 64'd1);
    ack_en = 1'b1;
    exp_rd.push_back(25'h300);
    ioctl_download = 1'b0;
    wait_for(0, 80, "ovf_load_tmo");
    chk("ovf_nwr",   n_wr - base_wr, 4);
    chk("ovf_wrq",   exp_wr.size(), 0);
    chk("ovf_stick", {63'b0, overflow}, 64'd1);
    wait_for(1, 30, "ovf_valid_tmo");

    // reset while a write is held
    base_wr        = n_wr;
    ack_en         = 1'b0;
    ioctl_download = 1'b1;
    tick();
    ioctl_byte(25'h20, 8'h77, 1'b0);
    tick();
    ioctl_wr = 1'b0;
    wait_for(4, 10, "mrst_we_tmo");
    reset = 1'b1;
    tick();
    chk("mrst_we",   {63'b0, sd_we},      64'd0);
    chk("mrst_crst", {63'b0, core_reset}, 64'd1);
    chk("mrst_load", {63'b0, rom_loaded}, 64'd0);
    chk("mrst_ovf",  {63'b0, overflow},   64'd0);
    reset  = 1'b0;
    ack_en = 1'b1;
    repeat (8) tick();
    chk("mrst_empty", n_wr - base_wr, 1);
    exp_rd.push_back(25'h300);
    ioctl_download = 1'b0;
    wait_for(0, 30, "mrst_load_tmo");
    wait_for(1, 30, "mrst_valid_tmo");
    chk("end_wrq", exp_wr.size(), 0);
    chk("end_rdq", exp_rd.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
